// File: rtl/seq_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Ports:
//   clock    - sole clock, rising edge
//   reset_b  - synchronous active-low reset
//   Start    - conversion request, honoured only while idle
//   Product  - unsigned binary input, 2*dp_width bits
//   Ready    - 1 while idle (including the Done cycle)
//   Done     - one-cycle pulse when BCD has been updated
//   BCD      - packed BCD result, digit 0 (units) in bits [3:0]
// n_digits must satisfy 10^n_digits > 2^(2*dp_width) so no digit overflows.
module seq_bcd_converter #(
    parameter int unsigned dp_width = 5,
    parameter int unsigned n_digits = 4
) (
    input  logic                    clock,
    input  logic                    reset_b,
    input  logic                    Start,
    input  logic [2*dp_width-1:0]   Product,
    output logic                    Ready,
    output logic                    Done,
    output logic [4*n_digits-1:0]   BCD
);

    localparam int unsigned bin_w = 2 * dp_width;
    localparam int unsigned bcd_w = 4 * n_digits;
    localparam int unsigned cnt_w = $clog2(bin_w + 1);

    typedef enum logic {
        S_idle    = 1'b0,
        S_convert = 1'b1
    } state_t;

    state_t             state;
    logic [bin_w-1:0]   bin_q;
    logic [bcd_w-1:0]   dig_q;
    logic [bcd_w-1:0]   dig_adj;
    logic [bcd_w-1:0]   dig_next;
    logic [cnt_w-1:0]   cnt_q;

    // Add 3 to every digit >= 5, then shift the next binary bit in at the bottom.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < int'(n_digits); i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
        dig_next = {dig_adj[bcd_w-2:0], bin_q[bin_w-1]};
    end

    // Control, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state <= S_idle;
            bin_q <= '0;
            dig_q <= '0;
            cnt_q <= '0;
            Ready <= 1'b1;
            Done  <= 1'b0;
            BCD   <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_idle: begin
                    if (Start) begin
                        bin_q <= Product;
                        dig_q <= '0;
                        cnt_q <= cnt_w'(bin_w);
                        Ready <= 1'b0;
                        state <= S_convert;
                    end
                end
                S_convert: begin
                    dig_q <= dig_next;
                    bin_q <= {bin_q[bin_w-2:0], 1'b0};
                    cnt_q <= cnt_q - cnt_w'(1);
                    // Last bit: publish the fully shifted digits this same edge.
                    if (cnt_q == cnt_w'(1)) begin
                        BCD   <= dig_next;
                        Done  <= 1'b1;
                        Ready <= 1'b1;
                        state <= S_idle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bcd_converter.sv
module tb_seq_bcd_converter;

    localparam int unsigned DW = 5;
    localparam int unsigned ND = 4;
    localparam int LATENCY = 2 * DW;

    logic              clock = 1'b0;
    logic              reset_b;
    logic              Start;
    logic [2*DW-1:0]   Product;
    logic              Ready;
    logic              Done;
    logic [4*ND-1:0]   BCD;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4*ND-1:0] hold_bcd;

    typedef struct {
        logic [2*DW-1:0] prod;
        logic [4*ND-1:0] bcd;
    } vec_t;

    vec_t vecs[10];

    seq_bcd_converter #(.dp_width(DW), .n_digits(ND)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .Start   (Start),
        .Product (Product),
        .Ready   (Ready),
        .Done    (Done),
        .BCD     (BCD)
    );

    always #5 clock = ~clock;

    // Decimal reference: peel digits with plain division.
    function automatic logic [4*ND-1:0] model(input int unsigned v);
        logic [4*ND-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(ND); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; ends at the negedge of the Done cycle with Start low.
    task automatic convert(input logic [2*DW-1:0] prod, input logic [4*ND-1:0] exp,
                           input string name, input bit poke);
        int cyc;
        bit seen, ready_ok, hold_ok;
        Start   = 1'b1;
        Product = prod;
        @(negedge clock);
        Start    = 1'b0;
        Product  = (2*DW)'($urandom);
        cyc      = 0;
        seen     = 0;
        ready_ok = 1;
        hold_ok  = 1;
        while (!seen && cyc < 2 * LATENCY) begin
            if (Done) begin
                seen = 1;
            end else begin
                if (Ready !== 1'b0) ready_ok = 0;
                if (BCD !== hold_bcd) hold_ok = 0;
                if (poke && (cyc == 3 || cyc == 9)) begin
                    Start   = 1'b1;
                    Product = 10'd7;
                end else begin
                    Start   = 1'b0;
                    Product = (2*DW)'($urandom);
                end
                @(negedge clock);
                cyc++;
            end
        end
        Start = 1'b0;
        check({name, "_latency"}, 32'(cyc), 32'(LATENCY));
        check({name, "_ready_low"}, 32'(ready_ok), 32'd1);
        check({name, "_bcd_hold"}, 32'(hold_ok), 32'd1);
        check({name, "_ready_done"}, 32'(Ready), 32'd1);
        check({name, "_bcd"}, 32'(BCD), 32'(exp));
        hold_bcd = exp;
    endtask

    // Idle cycles: no Done, Ready high, BCD unchanged.
    task automatic idle(input int n, input string name);
        bit ok;
        ok = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (Done !== 1'b0 || Ready !== 1'b1 || BCD !== hold_bcd) ok = 0;
        end
        check({name, "_idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        vecs[0] = '{10'd0,    16'h0000};
        vecs[1] = '{10'd961,  16'h0961};
        vecs[2] = '{10'd1023, 16'h1023};
        vecs[3] = '{10'd9,    16'h0009};
        vecs[4] = '{10'd10,   16'h0010};
        vecs[5] = '{10'd99,   16'h0099};
        vecs[6] = '{10'd100,  16'h0100};
        vecs[7] = '{10'd999,  16'h0999};
        vecs[8] = '{10'd1000, 16'h1000};
        vecs[9] = '{10'd555,  16'h0555};

        reset_b = 1'b0;
        Start   = 1'b1;
        Product = 10'd321;
        repeat (2) @(negedge clock);
        check("reset_ready", 32'(Ready), 32'd1);
        check("reset_done",  32'(Done),  32'd0);
        check("reset_bcd",   32'(BCD),   32'd0);
        Start    = 1'b0;
        reset_b  = 1'b1;
        hold_bcd = '0;
        idle(3, "post_reset");

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].prod, vecs[i].bcd, $sformatf("vec%0d", i), 0);
            idle(1, $sformatf("vec%0d", i));
        end

        // Start re-asserted mid-conversion must be ignored.
        convert(10'd500, 16'h0500, "restart_ignore", 1);
        idle(12, "restart_ignore");

        // Reset aborts a conversion: no Done, BCD cleared.
        Start   = 1'b1;
        Product = 10'd777;
        @(negedge clock);
        Start = 1'b0;
        repeat (5) @(negedge clock);
        reset_b = 1'b0;
        @(negedge clock);
        reset_b = 1'b1;
        check("abort_ready", 32'(Ready), 32'd1);
        check("abort_done",  32'(Done),  32'd0);
        check("abort_bcd",   32'(BCD),   32'd0);
        hold_bcd = '0;
        idle(12, "abort");
        convert(10'd42, 16'h0042, "after_abort", 0);
        idle(1, "after_abort");

        // Back-to-back: second Start in the Done cycle.
        convert(10'd123, 16'h0123, "b2b_first", 0);
        convert(10'd456, 16'h0456, "b2b_second", 0);
        idle(2, "b2b");

        for (int v = 0; v < 1024; v++) begin
            convert(10'(v), model(32'(v)), $sformatf("exh%0d", v), 0);
        end

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                convert(10'(a * b), model(32'(a * b)), $sformatf("mul%0dx%0d", a, b), 0);
            end
        end

        for (int i = 0; i < 100; i++) begin
            int unsigned v;
            int unsigned gap;
            v = $urandom_range(0, 1023);
            gap = $urandom_range(0, 2);
            convert(10'(v), model(v), $sformatf("rnd%0d", i), 0);
            if (gap != 0) idle(int'(gap), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_bcd_converter.md
SEQ_BCD_CONVERTER -- requirements
Module: seq_bcd_converter

Interface
REQ-001 Parameter dp_width, default 5, SHALL be the multiplier operand width; binary input width is 2*dp_width.
REQ-002 Parameter n_digits, default 4, SHALL be the number of BCD digits; legal only when 10^n_digits > 2^(2*dp_width).
REQ-003 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset_b  input  1  SHALL be a synchronous, active-low reset.
REQ-005 Start  input  1  SHALL be the request to convert the current Product, sampled on a rising edge.
REQ-006 Product  input  2*dp_width  SHALL be the unsigned binary value from the upstream multiplier.
REQ-007 Ready  output  1  SHALL be 1 when the block is idle and can accept Start.
REQ-008 Done  output  1  SHALL be a one-cycle pulse marking a completed conversion.
REQ-009 BCD  output  4*n_digits  SHALL be the packed BCD result, digit 0 (units) in bits [3:0].

Function
REQ-010 The block SHALL implement a two-state machine: S_idle and S_convert.
REQ-011 In S_idle with Start=1 at a rising edge, the block SHALL capture Product into a binary shift register, clear the internal digit register, load a bit counter with 2*dp_width, and enter S_convert.
REQ-012 Start SHALL be ignored in S_convert; Product changes after capture SHALL NOT affect the conversion.
REQ-013 Each S_convert edge SHALL first add 3 to every internal digit whose value is >= 5, then shift {digits, binary} left by one bit and decrement the counter.
REQ-014 All adjust/shift arithmetic SHALL be unsigned; no digit SHALL exceed 9 after a completed conversion.
REQ-015 The edge performing the final (2*dp_width-th) shift SHALL copy the adjusted-and-shifted digit value into the BCD output register, set Done, and return to S_idle.
REQ-016 Latency: Start accepted at edge k, result visible on BCD with Done=1 in the cycle following edge k+2*dp_width (10 edges for default).
REQ-017 Done SHALL be 1 for exactly one cycle per conversion and 0 otherwise.
REQ-018 Ready SHALL be 1 in S_idle (including the Done cycle) and 0 in S_convert.
REQ-019 Start asserted in the Done cycle SHALL be accepted, giving back-to-back conversions with no idle gap.
REQ-020 BCD SHALL change only at conversion completion and hold its value otherwise, including during a later conversion.
REQ-021 Product=0 SHALL yield BCD=0 with normal latency (no early termination).

Reset
REQ-022 With reset_b=0 at a rising edge, the block SHALL enter S_idle, set BCD=0, Done=0, Ready=1, clear counter and internal registers.
REQ-023 Reset SHALL take priority over Start and over an in-progress conversion; an aborted conversion SHALL produce no Done and no BCD update.
REQ-024 Outputs between power-up and the first reset edge SHALL be unspecified.

Verification
REQ-025 Reset, then Start with Product=0 -> Done exactly 10 cycles later, BCD=16'h0000, Ready=1 throughout idle.
REQ-026 Product=961 (31*31) -> BCD=16'h0961; Product=1023 -> BCD=16'h1023; Product=9 -> BCD=16'h0009.
REQ-027 Start with Product=500, re-assert Start with Product=7 at cycles 3 and 9 of the conversion -> single Done, BCD=16'h0500, the re-assertions ignored.
REQ-028 Start with Product=777, reset_b=0 on cycle 5 -> no Done, BCD=16'h0000, Ready=1 next cycle; a following Start with 42 -> BCD=16'h0042.
REQ-029 Start with Product=123, assert Start with Product=456 in the Done cycle -> BCD=16'h0123 holds for 10 cycles, then BCD=16'h0456 with a second Done pulse.
REQ-030 Exhaustive: drive all 1024 Product values, and separately all 32x32 operand pairs through the upstream multiplier, comparing each BCD against a bench decimal model; zero mismatches required.
